qisp_writeback: RTL

Writeback and architectural-state block for the qisp core; the consumer of the ALU's result and write-enable outputs. It holds the 16×16 register file, the program counter (PC) and the queue pointer (QP). It applies ALU writebacks qualified by the bus strobe and serves the two ALU operand read ports with same-cycle bypass. It also implements the test/skip mechanism driven by the ALU's `ts` flag.

---
 rtl/qisp_writeback.sv | 102 ++++++++++
 1 files changed

// File: rtl/qisp_writeback.sv
// Writeback and architectural state for the qisp core: register file with
// same-cycle bypass, program counter, queue pointer and the test/skip flag.
module qisp_writeback #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] RESET_QP = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bs,
    input  logic [15:0] result,
    input  logic        wr_pc,
    input  logic        wr_reg,
    input  logic        wr_qp,
    input  logic        ts,
    input  logic [3:0]  sel_rd,
    input  logic [3:0]  rd_a_sel,
    input  logic [3:0]  rd_b_sel,
    output logic [15:0] rd_a,
    output logic [15:0] rd_b,
    input  logic        pc_adv,
    output logic [15:0] pc,
    output logic [15:0] qp,
    output logic        skip_pend
);

    logic [15:0] rf_q [16];
    logic [15:0] pc_q, pc_d;
    logic [15:0] qp_q, qp_d;
    logic        skip_q, skip_d;

    logic wb;
    logic tst;
    logic reg_we;

    assign wb     = bs & ~ts;
    assign tst    = bs & ts;
    assign reg_we = wb & wr_reg & (sel_rd != 4'd0);

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                rf_q[i] <= 16'h0000;
            end
        end else if (reg_we) begin
            rf_q[sel_rd] <= result;
        end
    end

    always_comb begin
        rd_a = rf_q[rd_a_sel];
        if (reg_we && (sel_rd == rd_a_sel)) begin
            rd_a = result;
        end
    end

    always_comb begin
        rd_b = rf_q[rd_b_sel];
        if (reg_we && (sel_rd == rd_b_sel)) begin
            rd_b = result;
        end
    end

    // A fresh zero test re-arms the skip even while an armed skip is consumed.
    always_comb begin
        pc_d   = pc_q;
        skip_d = skip_q;
        qp_d   = qp_q;
        if (wb && wr_qp) begin
            qp_d = result;
        end
        if (wb && wr_pc) begin
            pc_d   = result;
            skip_d = 1'b0;
        end else if (pc_adv && skip_q) begin
            pc_d   = pc_q + 16'd2;
            skip_d = 1'b0;
        end else if (pc_adv) begin
            pc_d = pc_q + 16'd1;
        end
        if (tst && (result == 16'h0000)) begin
            skip_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            qp_q   <= RESET_QP;
            skip_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            qp_q   <= qp_d;
            skip_q <= skip_d;
        end
    end

    assign pc        = pc_q;
    assign qp        = qp_q;
    assign skip_pend = skip_q;

endmodule
